// File: rtl/led_pwm_ramp.sv
// 8-channel LED PWM driver: ramps a commanded duty toward its target and drives
// glitch-free PWM, with duty/mask changes taking effect only at period boundaries.
module led_pwm_ramp #(
    parameter int unsigned PRESCALE = 49
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_duty_i,
    input  logic [7:0] cmd_mask_i,
    input  logic [7:0] cmd_rate_i,
    output logic [7:0] led_o,
    output logic       busy_o,
    output logic [7:0] cur_duty_o
);

    localparam int unsigned PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       rate_q, rate_d;
    logic [7:0]       rate_cnt_q, rate_cnt_d;
    logic [7:0]       cur_duty_q, cur_duty_d;
    logic [7:0]       duty_act_q, duty_act_d;
    logic [7:0]       mask_act_q, mask_act_d;
    logic [7:0]       led_q, led_d;

    logic       pwm_tick;
    logic       period_end;
    logic       transfer;
    logic [7:0] step_duty;

    assign pwm_tick    = (pre_cnt_q == PRE_MAX);
    assign period_end  = pwm_tick && (pwm_cnt_q == 8'hFF);
    assign cmd_ready_o = (state_q == IDLE) && rst_ni;
    assign transfer    = cmd_valid_i && cmd_ready_o;
    assign step_duty   = (cur_duty_q < target_q) ? cur_duty_q + 8'd1 : cur_duty_q - 8'd1;

    assign led_o      = led_q;
    assign busy_o     = (state_q == RAMP);
    assign cur_duty_o = cur_duty_q;

    // Timebase, shadow registers and the PWM compare; shadows only move at period ends.
    always_comb begin
        pre_cnt_d  = pwm_tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d  = pwm_tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_act_d = period_end ? cur_duty_q : duty_act_q;
        mask_act_d = period_end ? mask_q : mask_act_q;
        led_d      = mask_act_q & {8{pwm_cnt_q < duty_act_q}};
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        mask_d     = mask_q;
        rate_d     = rate_q;
        rate_cnt_d = rate_cnt_q;
        cur_duty_d = cur_duty_q;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    target_d = cmd_duty_i;
                    mask_d   = cmd_mask_i;
                    rate_d   = cmd_rate_i;
                    if (cmd_rate_i == 8'd0) begin
                        cur_duty_d = cmd_duty_i;
                    end else if (cmd_duty_i != cur_duty_q) begin
                        state_d    = RAMP;
                        rate_cnt_d = 8'd0;
                    end
                end
            end
            RAMP: begin
                // rate_q is never 0 here, so rate_q-1 cannot underflow.
                if (period_end) begin
                    if (rate_cnt_q == rate_q - 8'd1) begin
                        rate_cnt_d = 8'd0;
                        cur_duty_d = step_duty;
                        if (step_duty == target_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        rate_cnt_d = rate_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= 8'd0;
            target_q   <= 8'd0;
            mask_q     <= 8'd0;
            rate_q     <= 8'd0;
            rate_cnt_q <= 8'd0;
            cur_duty_q <= 8'd0;
            duty_act_q <= 8'd0;
            mask_act_q <= 8'd0;
            led_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            target_q   <= target_d;
            mask_q     <= mask_d;
            rate_q     <= rate_d;
            rate_cnt_q <= rate_cnt_d;
            cur_duty_q <= cur_duty_d;
            duty_act_q <= duty_act_d;
            mask_act_q <= mask_act_d;
            led_q      <= led_d;
        end
    end

endmodule

// File: doc/led_pwm_ramp.md
Name: led_pwm_ramp

Overview:
- 8-channel LED brightness driver that sits directly in front of the board LED pins (ld1–ld8).
- Replaces the fixed on/off breath pattern with a commanded 8-bit PWM duty.
- An upstream pattern sequencer issues brightness commands over a valid/ready handshake. This block ramps the duty toward each target at a commanded rate and drives glitch-free PWM on the masked channels.

Parameters:
PRESCALE, 49, PWM tick every PRESCALE+1 clocks (49 → 1 us tick at 50 MHz; PWM period 256 ticks = 256 us)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low
cmd_valid  input  1  command offered by upstream
cmd_ready  output  1  block can accept a command
cmd_duty  input  8  target duty, 0..255
cmd_mask  input  8  channel enable, bit i → led[i]
cmd_rate  input  8  PWM periods per duty LSB step; 0 = jump immediately
led  output  8  registered PWM outputs, active-high
busy  output  1  ramp in progress
cur_duty  output  8  current (pre-shadow) duty value

Behaviour:
- Reset: all state is cleared on any clk edge with rst=0.
  - led=0, busy=0, cur_duty=0.
  - Target, mask, rate registers, shadow registers, and all counters = 0.
  - State = IDLE.
- cmd_ready = (state==IDLE) && rst (combinational); it is 0 while rst is low.
- Prescaler: pre_cnt counts 0..PRESCALE and wraps to 0. pwm_tick = (pre_cnt==PRESCALE).
- PWM counter: pwm_cnt is 8-bit. It increments on pwm_tick and wraps 255→0.
  - period_end = pwm_tick && pwm_cnt==255.
- Shadow registers:
  - duty_act <= cur_duty and mask_act <= mask_q, only on period_end.
  - Duty and mask changes therefore take effect only at PWM period boundaries (no runt pulses).
- Output: led[i] <= mask_act[i] && (pwm_cnt < duty_act), registered.
  - led lags pwm_cnt by 1 clk.
  - Duty 0 → never on. Duty 255 → on 255 of 256 ticks.
- Handshake: a transfer occurs when cmd_valid && cmd_ready. On transfer, latch target_q=cmd_duty, mask_q=cmd_mask, rate_q=cmd_rate. Then:
  - rate=0: cur_duty <= cmd_duty in the same edge; stay IDLE.
  - rate≠0 and cmd_duty==cur_duty: stay IDLE; busy stays 0.
  - Otherwise: go to RAMP, rate_cnt <= 0.
- State IDLE: busy=0; accepts commands as above.
- State RAMP: busy=1, cmd_ready=0. On each period_end:
  - If rate_cnt==rate_q-1: rate_cnt <= 0, and cur_duty moves 1 LSB toward target_q (+1 if below, −1 if above). If the new value equals target_q, go to IDLE.
  - Otherwise rate_cnt <= rate_cnt+1.
- RAMP exits only on reaching the target or on reset. Commands cannot abort a ramp.
- Arithmetic: cur_duty never wraps; stepping is bounded by target_q, which lies in 0..255. rate_cnt is 8-bit.
- Simultaneous events:
  - A transfer and a period_end in the same cycle: shadows load the old cur_duty/mask_q; new values reach led at the following period_end.
  - Upstream may hold cmd_valid during RAMP. The command is accepted in the first IDLE cycle.
- Reset mid-operation (rst low for ≥1 edge during RAMP): immediate return to reset values. The first command after rst returns high is accepted normally.
- Step timing: a ramp of N LSBs with rate R completes after N·R period_ends. busy deasserts on the edge that writes the final step.

Test Plan:
- Reset, PRESCALE=1 (period 512 clk): hold rst=0 for 3 clk, then release → led=0, busy=0, cur_duty=0, cmd_ready=1 from the first edge after release.
- Jump: cmd_duty=64, mask=0xFF, rate=0 → cur_duty=64 next edge, busy stays 0. After the next period_end, every led is high for exactly 128 clk of each 512-clk period.
- Ramp up from 0: duty=4, rate=2, mask=0xFF → busy=1, cmd_ready=0. cur_duty steps 1,2,3,4 on every 2nd period_end. busy falls after the 8th period_end. A second cmd_valid held throughout is accepted the following clk.
- Ramp down with mask: from 4, duty=1, rate=1, mask=0x0F → led[7:4]=0 from the next period_end. cur_duty steps 3,2,1 on consecutive period_ends.
- Extremes: duty=255, rate=0 → each led high 510 of 512 clk. Duty=0 → led constantly 0. Then duty=0, rate=5 (already equal) → busy never asserts.
- Reset mid-ramp: 0→200, rate=1; pulse rst=0 for 1 clk after 10 steps → all outputs 0, state IDLE. A new duty=8, rate=0 command is accepted and cur_duty=8.
